// File: rtl/game_controller.sv
// game_controller: round sequencer for the binary counting game.
// Draws a pseudo-random 8-bit target and converts it to BCD by repeated
// subtraction. It fires digit_selector to show the digits, then scores the
// player's binary answer. A game is ROUNDS rounds long.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   start_btn, submit_btn     - debounced buttons (rising edges act)
//   answer[7:0]               - player's binary answer
//   sel_state[1:0]            - digit_selector state (0 hund, 1 tens, 2 ones, 3 blank)
//   sel_trigger               - one-cycle pulse starting digit_selector
//   digit_bcd[3:0]            - digit selected by sel_state, 4'hF when blank (combinational)
//   result_ok, result_fail    - verdict, held for RESULT_TIME cycles
//   score[3:0], round[3:0]    - correct answers / completed rounds this game
//   game_over                 - high once all rounds are played
module game_controller #(
  parameter int unsigned ROUNDS      = 5,
  parameter int unsigned INPUT_TIME  = 10000,
  parameter int unsigned RESULT_TIME = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       submit_btn,
  input  logic [7:0] answer,
  input  logic [1:0] sel_state,
  output logic       sel_trigger,
  output logic [3:0] digit_bcd,
  output logic       result_ok,
  output logic       result_fail,
  output logic [3:0] score,
  output logic [3:0] round,
  output logic       game_over
);

  // One shared timer covers both the answer window and the verdict hold.
  localparam int unsigned TMAX = (INPUT_TIME > RESULT_TIME) ? INPUT_TIME : RESULT_TIME;
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SHOW,
    S_INPUT,
    S_RESULT,
    S_GAMEOVER
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            start_prev_q, start_prev_d;
  logic            submit_prev_q, submit_prev_d;
  logic [7:0]      target_q, target_d;
  logic [7:0]      rem_q, rem_d;
  logic [3:0]      hund_q, hund_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic            seen2_q, seen2_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            sel_trigger_q, sel_trigger_d;
  logic            result_ok_q, result_ok_d;
  logic            result_fail_q, result_fail_d;
  logic [3:0]      score_q, score_d;
  logic [3:0]      round_q, round_d;
  logic            game_over_q, game_over_d;

  logic            start_edge;
  logic            submit_edge;
  logic            new_round;

  assign start_edge  = start_btn & ~start_prev_q;
  assign submit_edge = submit_btn & ~submit_prev_q;

  // Next-state and datapath logic
  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    start_prev_d  = start_btn;
    submit_prev_d = submit_btn;
    target_d      = target_q;
    rem_d         = rem_q;
    hund_d        = hund_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
    seen2_d       = seen2_q;
    timer_d       = timer_q;
    sel_trigger_d = 1'b0;
    result_ok_d   = result_ok_q;
    result_fail_d = result_fail_q;
    score_d       = score_q;
    round_d       = round_q;
    game_over_d   = game_over_q;
    new_round     = 1'b0;

    unique case (state_q)
      S_IDLE, S_GAMEOVER: begin
        if (start_edge) begin
          score_d     = 4'd0;
          round_d     = 4'd0;
          game_over_d = 1'b0;
          new_round   = 1'b1;
        end
      end

      // One subtraction step per cycle; the remainder below 10 is the ones digit
      S_CONVERT: begin
        if (rem_q >= 8'd100) begin
          rem_d  = rem_q - 8'd100;
          hund_d = hund_q + 4'd1;
        end else if (rem_q >= 8'd10) begin
          rem_d  = rem_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d        = rem_q[3:0];
          state_d       = S_SHOW;
          sel_trigger_d = 1'b1;
          seen2_d       = 1'b0;
        end
      end

      // Wait until the selector has shown the ones digit and gone blank
      S_SHOW: begin
        if (sel_state == 2'd2) begin
          seen2_d = 1'b1;
        end
        if (seen2_q && (sel_state == 2'd3)) begin
          state_d = S_INPUT;
          timer_d = '0;
        end
      end

      // A submit in the timeout cycle takes priority over the timeout
      S_INPUT: begin
        if (submit_edge) begin
          if (answer == target_q) begin
            result_ok_d = 1'b1;
            score_d     = (score_q == 4'd15) ? score_q : score_q + 4'd1;
          end else begin
            result_fail_d = 1'b1;
          end
          round_d = round_q + 4'd1;
          timer_d = '0;
          state_d = S_RESULT;
        end else if (timer_q == TW'(INPUT_TIME - 1)) begin
          result_fail_d = 1'b1;
          round_d       = round_q + 4'd1;
          timer_d       = '0;
          state_d       = S_RESULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_RESULT: begin
        if (timer_q == TW'(RESULT_TIME - 1)) begin
          result_ok_d   = 1'b0;
          result_fail_d = 1'b0;
          timer_d       = '0;
          if (round_q == 4'(ROUNDS)) begin
            state_d     = S_GAMEOVER;
            game_over_d = 1'b1;
          end else begin
            new_round = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Draw a fresh target and restart the BCD conversion
    if (new_round) begin
      target_d = lfsr_q;
      rem_d    = lfsr_q;
      hund_d   = 4'd0;
      tens_d   = 4'd0;
      ones_d   = 4'd0;
      state_d  = S_CONVERT;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 8'h01;
      start_prev_q  <= 1'b1;
      submit_prev_q <= 1'b1;
      target_q      <= 8'd0;
      rem_q         <= 8'd0;
      hund_q        <= 4'd0;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      seen2_q       <= 1'b0;
      timer_q       <= '0;
      sel_trigger_q <= 1'b0;
      result_ok_q   <= 1'b0;
      result_fail_q <= 1'b0;
      score_q       <= 4'd0;
      round_q       <= 4'd0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      start_prev_q  <= start_prev_d;
      submit_prev_q <= submit_prev_d;
      target_q      <= target_d;
      rem_q         <= rem_d;
      hund_q        <= hund_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      seen2_q       <= seen2_d;
      timer_q       <= timer_d;
      sel_trigger_q <= sel_trigger_d;
      result_ok_q   <= result_ok_d;
      result_fail_q <= result_fail_d;
      score_q       <= score_d;
      round_q       <= round_d;
      game_over_q   <= game_over_d;
    end
  end

  // Digit mux for the 7-segment decoder
  always_comb begin
    digit_bcd = 4'hF;
    unique case (sel_state)
      2'd0:    digit_bcd = hund_q;
      2'd1:    digit_bcd = tens_q;
      2'd2:    digit_bcd = ones_q;
      default: digit_bcd = 4'hF;
    endcase
  end

  assign sel_trigger = sel_trigger_q;
  assign result_ok   = result_ok_q;
  assign result_fail = result_fail_q;
  assign score       = score_q;
  assign round       = round_q;
  assign game_over   = game_over_q;

endmodule
